fft_out_serializer: RTL and testbench
=====================================

Name: fft_out_serializer

Overview:
- Downstream stage of the 16-point radix-4 FFT core. Captures the 16 parallel complex output bins (16-bit re/im each) as one frame.
- Streams the frame out one bin per cycle over a valid/ready interface to serial consumers (UART/DMA/magnitude unit).
- Ping-pong double buffering: a new frame is captured while the previous one drains.

Parameters:
- DATA_W, 16, width of each real/imag component (two's complement).
- NPOINT, 16, bins per frame; fixed at 16 for this core (radix-4, two digits).
- IDX_W, 4, bin index width, equal to log2(NPOINT).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock domain only.
- frame_valid  in  1  parallel FFT frame present on in_re/in_im.
- frame_ready  out  1  a bank is free; frame is accepted when frame_valid && frame_ready.
- in_re  in  NPOINT*DATA_W  packed real bins; slot s occupies bits [s*DATA_W +: DATA_W].
- in_im  in  NPOINT*DATA_W  packed imaginary bins, same packing.
- out_valid  out  1  out_re/out_im/out_index are valid.
- out_ready  in  1  consumer accepts the current bin.
- out_re  out  DATA_W  real part of the current bin.
- out_im  out  DATA_W  imaginary part of the current bin.
- out_index  out  IDX_W  stream position 0..15 within the frame.
- out_last  out  1  high with out_valid when out_index == NPOINT-1.
- frame_drop  out  1  one-cycle pulse: a frame was offered while frame_ready was low and has been discarded.

Behaviour:
- State: bank_full[1:0], wr_sel, rd_sel, rd_idx (IDX_W), frame_drop register.
- Reset values: bank_full=00, wr_sel=0, rd_sel=0, rd_idx=0, frame_drop=0. Resulting outputs: out_valid=0, out_last=0, frame_ready=1, out_index=0, out_re/out_im=0 (bank storage cleared on reset).
- frame_ready = !bank_full[wr_sel]. It is computed from registered state only, so a bank freed this cycle is not writable until next cycle.
- Capture, on an edge where frame_valid && frame_ready:
  - bank[wr_sel] <= in_re/in_im.
  - bank_full[wr_sel] <= 1.
  - wr_sel toggles.
- Read side:
  - out_valid = bank_full[rd_sel].
  - out_re/out_im = bank[rd_sel] slot sel(rd_idx).
  - out_index = rd_idx.
- Transfer = out_valid && out_ready:
  - rd_idx increments.
  - On the transfer with rd_idx == NPOINT-1: rd_idx wraps to 0, bank_full[rd_sel] <= 0, rd_sel toggles.
- Latency: frame accepted at edge N gives out_valid from cycle N+1 if the read bank was empty. The frame drains in exactly 16 cycles with out_ready held high.
- The second buffered frame follows the first with no bubble.
- Stall: with out_ready=0, all outputs hold stable. Capture into the other bank continues independently.
- Simultaneous capture into bank A and final drain of bank B on the same edge: both take effect.
- Drop: frame_valid && !frame_ready at edge N gives frame_drop=1 during cycle N+1 only. The frame is not stored and no state changes.
- Reset mid-stream: all state returns to reset values on the next edge; partially streamed frames are discarded.

Optional Feature:
- FFT_DIGIT_REVERSE_EN
  - Defined: sel(i) = {i[1:0], i[3:2]} (radix-4 digit reversal), so the stream emits bins in natural frequency order from the core's digit-reversed output.
  - Undefined: sel(i) = i; slots are streamed in capture order.
- out_index always equals the stream position.

Decomposition:
- Package fft_pkg:
  - DATA_W, NPOINT, IDX_W constants.
  - complex_t typedef (re, im).
  - digit_rev4 function.
- Sub-module fft_frame_bank: one NPOINT-entry complex storage with load enable, synchronous reset clear and indexed combinational read. Instantiated twice.
- Control FSM and pointers live in fft_out_serializer.

Test Plan:
- Single frame, macro off, in_re slot s = 100+s, in_im slot s = -s, out_ready=1 -> out_valid cycles N+1..N+16; out_re 100..115, out_im 0..-15; out_last only on index 15; frame_ready stays 1.
- Macro on, same frame -> positions 0,1,2,3,4,5 output re 100,104,108,112,101,105.
- Frames A and B on consecutive cycles, then C with out_ready=0 -> frame_ready=0 after B; C gives a frame_drop pulse. With out_ready=1, 32 contiguous valid cycles A then B, no bubble.
- Backpressure: out_ready alternating 1/0 -> every bin delivered exactly once in order; outputs stable during stall cycles.
- Capture of a new frame on the same edge as the index-15 transfer of the other bank -> no drop, correct bank_full, next frame streams immediately.
- reset=1 for one cycle at out_index 7 -> next cycle out_valid=0, out_index=0, frame_ready=1, frame_drop=0; a subsequent frame streams from index 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, complex sample type and radix-4 digit reversal for the FFT output path.
package fft_pkg;

    localparam int DATA_W = 16;
    localparam int NPOINT = 16;
    localparam int IDX_W  = 4;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } complex_t;

    // Swaps the two base-4 digits of a bin index.
    function automatic logic [IDX_W-1:0] digit_rev4(input logic [IDX_W-1:0] i);
        return {i[1:0], i[3:2]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of NPOINT complex bins: parallel load, cleared on reset, indexed combinational read.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [NPOINT*DATA_W-1:0] in_re,
    input  logic [NPOINT*DATA_W-1:0] in_im,
    input  logic [IDX_W-1:0]         rd_addr,
    output complex_t                 rd_data
);

    complex_t mem [NPOINT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NPOINT; s++) begin
                mem[s] <= '0;
            end
        end else if (load) begin
            for (int s = 0; s < NPOINT; s++) begin
                mem[s].re <= in_re[s*DATA_W +: DATA_W];
                mem[s].im <= in_im[s*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_out_serializer.sv
// Ping-pong frame buffer that streams 16 parallel FFT bins one per cycle over valid/ready.
// Define FFT_DIGIT_REVERSE_EN to emit bins in natural order from the core's digit-reversed output.
module fft_out_serializer
    import fft_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    input  logic [NPOINT*DATA_W-1:0] in_re,
    input  logic [NPOINT*DATA_W-1:0] in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_re,
    output logic [DATA_W-1:0]        out_im,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last,
    output logic                     frame_drop
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOINT - 1);

    logic [1:0]       bank_full;
    logic             wr_sel;
    logic             rd_sel;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rd_slot;
    logic             capture;
    logic             transfer;
    complex_t         rd_data0;
    complex_t         rd_data1;
    complex_t         rd_data;

    assign frame_ready = !bank_full[wr_sel];
    assign capture     = frame_valid && frame_ready;
    assign out_valid   = bank_full[rd_sel];
    assign transfer    = out_valid && out_ready;

`ifdef FFT_DIGIT_REVERSE_EN
    assign rd_slot = digit_rev4(rd_idx);
`else
    assign rd_slot = rd_idx;
`endif

    fft_frame_bank u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .load    (capture && !wr_sel),
        .in_re   (in_re),
        .in_im   (in_im),
        .rd_addr (rd_slot),
        .rd_data (rd_data0)
    );

    fft_frame_bank u_bank1 (
        .clk     (clk),
        .reset   (reset),
        .load    (capture && wr_sel),
        .in_re   (in_re),
        .in_im   (in_im),
        .rd_addr (rd_slot),
        .rd_data (rd_data1)
    );

    assign rd_data   = rd_sel ? rd_data1 : rd_data0;
    assign out_re    = rd_data.re;
    assign out_im    = rd_data.im;
    assign out_index = rd_idx;
    assign out_last  = out_valid && (rd_idx == LAST_IDX);

    // Capture and final drain can hit the same edge; they always target different banks.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full  <= 2'b00;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            rd_idx     <= '0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= frame_valid && !frame_ready;
            if (capture) begin
                bank_full[wr_sel] <= 1'b1;
                wr_sel            <= ~wr_sel;
            end
            if (transfer) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_idx == LAST_IDX) begin
                    bank_full[rd_sel] <= 1'b0;
                    rd_sel            <= ~rd_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Self-checking bench for fft_out_serializer against a two-deep frame FIFO model.
// Honours FFT_DIGIT_REVERSE_EN the same way as the design build.
module tb_fft_out_serializer;
    import fft_pkg::*;

    typedef struct {
        logic [NPOINT*DATA_W-1:0] re;
        logic [NPOINT*DATA_W-1:0] im;
    } frame_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     frame_valid;
    logic                     frame_ready;
    logic [NPOINT*DATA_W-1:0] in_re;
    logic [NPOINT*DATA_W-1:0] in_im;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_re;
    logic [DATA_W-1:0]        out_im;
    logic [IDX_W-1:0]         out_index;
    logic                     out_last;
    logic                     frame_drop;

    int n_compared = 0;
    int n_mismatch = 0;
    int cyc = 0;

    frame_t model_q[$];
    int     model_pos  = 0;
    bit     model_drop = 1'b0;
    frame_t idle_f;

    fft_out_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .in_re       (in_re),
        .in_im       (in_im),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_re      (out_re),
        .out_im      (out_im),
        .out_index   (out_index),
        .out_last    (out_last),
        .frame_drop  (frame_drop)
    );

    always #5 clk = ~clk;

    // Which captured slot appears at stream position i.
    function automatic int sel_of(input int i);
`ifdef FFT_DIGIT_REVERSE_EN
        return (i % 4) * 4 + (i / 4);
`else
        return i;
`endif
    endfunction

    function automatic frame_t make_ramp();
        frame_t f;
        for (int s = 0; s < NPOINT; s++) begin
            f.re[s*DATA_W +: DATA_W] = DATA_W'(100 + s);
            f.im[s*DATA_W +: DATA_W] = DATA_W'(-s);
        end
        return f;
    endfunction

    function automatic frame_t make_random();
        frame_t f;
        for (int s = 0; s < NPOINT; s++) begin
            f.re[s*DATA_W +: DATA_W] = DATA_W'($urandom);
            f.im[s*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
        return f;
    endfunction

    // One clock: drive inputs, compare outputs with the model, then advance the model past the edge.
    task automatic step(input bit rst, input bit fv, input bit ordy, input frame_t f);
        bit               exp_valid;
        bit               exp_ready;
        bit               exp_last;
        logic [IDX_W-1:0] exp_idx;
        logic [DATA_W-1:0] exp_re;
        logic [DATA_W-1:0] exp_im;
        frame_t           head;
        int               slot;

        reset       = rst;
        frame_valid = fv;
        out_ready   = ordy;
        in_re       = f.re;
        in_im       = f.im;

        exp_valid = (model_q.size() > 0);
        exp_ready = (model_q.size() < 2);
        exp_idx   = model_pos[IDX_W-1:0];
        exp_last  = exp_valid && (model_pos == NPOINT - 1);

        n_compared++;
        if (out_valid !== exp_valid) begin
            n_mismatch++;
            $display("[TB] FAIL out_valid cyc=%0d got %b expected %b", cyc, out_valid, exp_valid);
        end
        n_compared++;
        if (frame_ready !== exp_ready) begin
            n_mismatch++;
            $display("[TB] FAIL frame_ready cyc=%0d got %b expected %b", cyc, frame_ready, exp_ready);
        end
        n_compared++;
        if (frame_drop !== model_drop) begin
            n_mismatch++;
            $display("[TB] FAIL frame_drop cyc=%0d got %b expected %b", cyc, frame_drop, model_drop);
        end
        n_compared++;
        if (out_index !== exp_idx) begin
            n_mismatch++;
            $display("[TB] FAIL out_index cyc=%0d got %0d expected %0d", cyc, out_index, exp_idx);
        end
        n_compared++;
        if (out_last !== exp_last) begin
            n_mismatch++;
            $display("[TB] FAIL out_last cyc=%0d got %b expected %b", cyc, out_last, exp_last);
        end
        if (exp_valid) begin
            head   = model_q[0];
            slot   = sel_of(model_pos);
            exp_re = head.re[slot*DATA_W +: DATA_W];
            exp_im = head.im[slot*DATA_W +: DATA_W];
            n_compared++;
            if (out_re !== exp_re || out_im !== exp_im) begin
                n_mismatch++;
                $display("[TB] FAIL out_data cyc=%0d pos=%0d got re=%h im=%h expected re=%h im=%h",
                         cyc, model_pos, out_re, out_im, exp_re, exp_im);
            end
        end

        if (rst) begin
            model_q.delete();
            model_pos  = 0;
            model_drop = 1'b0;
        end else begin
            model_drop = fv && !exp_ready;
            if (exp_valid && ordy) begin
                model_pos++;
                if (model_pos == NPOINT) begin
                    void'(model_q.pop_front());
                    model_pos = 0;
                end
            end
            if (fv && exp_ready) begin
                model_q.push_back(f);
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, idle_f);
        n_compared++;
        if (out_re !== '0 || out_im !== '0) begin
            n_mismatch++;
            $display("[TB] FAIL reset_data got re=%h im=%h expected 0 0", out_re, out_im);
        end
        step(1'b0, 1'b0, 1'b0, idle_f);
    endtask

    task automatic test_single_frame();
        int valid_cnt = 0;
        step(1'b0, 1'b1, 1'b1, make_ramp());
        for (int k = 0; k < 18; k++) begin
            if (out_valid) valid_cnt++;
            step(1'b0, 1'b0, 1'b1, idle_f);
        end
        n_compared++;
        if (valid_cnt !== NPOINT) begin
            n_mismatch++;
            $display("[TB] FAIL single_len got %0d expected %0d", valid_cnt, NPOINT);
        end
    endtask

    task automatic test_back_to_back();
        int valid_cnt = 0;
        step(1'b0, 1'b1, 1'b0, make_random());
        step(1'b0, 1'b1, 1'b0, make_random());
        step(1'b0, 1'b1, 1'b0, make_random());
        n_compared++;
        if (frame_drop !== 1'b1) begin
            n_mismatch++;
            $display("[TB] FAIL drop_pulse got %b expected 1", frame_drop);
        end
        step(1'b0, 1'b0, 1'b0, idle_f);
        for (int k = 0; k < 34; k++) begin
            if (out_valid) valid_cnt++;
            step(1'b0, 1'b0, 1'b1, idle_f);
        end
        n_compared++;
        if (valid_cnt !== 2 * NPOINT) begin
            n_mismatch++;
            $display("[TB] FAIL b2b_len got %0d expected %0d", valid_cnt, 2 * NPOINT);
        end
    endtask

    task automatic test_backpressure();
        step(1'b0, 1'b1, 1'b0, make_random());
        for (int k = 0; k < 36; k++) begin
            step(1'b0, 1'b0, (k % 2) == 0, idle_f);
        end
    endtask

    task automatic test_simultaneous();
        step(1'b0, 1'b1, 1'b1, make_ramp());
        for (int k = 0; k < 20 && model_pos != NPOINT - 1; k++) begin
            step(1'b0, 1'b0, 1'b1, idle_f);
        end
        step(1'b0, 1'b1, 1'b1, make_random());
        n_compared++;
        if (out_valid !== 1'b1 || out_index !== '0 || frame_drop !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL simul_handoff got valid=%b idx=%0d drop=%b expected 1 0 0",
                     out_valid, out_index, frame_drop);
        end
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 1'b0, 1'b1, idle_f);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 1'b1, make_ramp());
        for (int k = 0; k < 20 && model_pos != 7; k++) begin
            step(1'b0, 1'b0, 1'b1, idle_f);
        end
        step(1'b1, 1'b0, 1'b1, idle_f);
        n_compared++;
        if (out_valid !== 1'b0 || out_index !== '0 || frame_ready !== 1'b1 || frame_drop !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL mid_reset got valid=%b idx=%0d ready=%b drop=%b expected 0 0 1 0",
                     out_valid, out_index, frame_ready, frame_drop);
        end
        step(1'b0, 1'b1, 1'b1, make_random());
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 1'b0, 1'b1, idle_f);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            step(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), make_random());
        end
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b0, 1'b1, idle_f);
        end
    endtask

    initial begin
        idle_f.re   = '0;
        idle_f.im   = '0;
        reset       = 1'b1;
        frame_valid = 1'b0;
        out_ready   = 1'b0;
        in_re       = '0;
        in_im       = '0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] starting fft_out_serializer bench");
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
